// File: rtl/seq_shift_add_multiplier.sv
// Unsigned N x N shift-and-add multiplier: one N-bit add per cycle, and a
// 2N-bit product {A,Q} after N iterations.
module seq_shift_add_multiplier #(
    parameter int unsigned N = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [N-1:0]   multiplicand,
    input  logic [N-1:0]   multiplier,
    output logic           busy,
    output logic           done,
    output logic [2*N-1:0] product
);

    localparam int unsigned CW = $clog2(N + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t         state_q, state_d;
    logic [N-1:0]   m_q, m_d;
    logic [N-1:0]   a_q, a_d;
    logic [N-1:0]   q_q, q_d;
    logic [CW-1:0]  count_q, count_d;
    logic [N-1:0]   addend;
    logic [N:0]     sum;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            m_q     <= '0;
            a_q     <= '0;
            q_q     <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            m_q     <= m_d;
            a_q     <= a_d;
            q_q     <= q_d;
            count_q <= count_d;
        end
    end

    // The adder carry is shifted straight into A's MSB, so a separate C
    // register would only ever hold 0 between iterations.
    always_comb begin
        state_d = state_q;
        m_d     = m_q;
        a_d     = a_q;
        q_d     = q_q;
        count_d = count_q;
        addend  = q_q[0] ? m_q : '0;
        sum     = {1'b0, a_q} + {1'b0, addend};

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    m_d     = multiplicand;
                    q_d     = multiplier;
                    a_d     = '0;
                    count_d = CW'(N);
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                a_d     = sum[N:1];
                q_d     = {sum[0], q_q[N-1:1]};
                count_d = count_q - CW'(1);
                if (count_q == CW'(1)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign busy    = (state_q != S_IDLE);
    assign done    = (state_q == S_DONE);
    assign product = {a_q, q_q};

endmodule

// File: tb/tb_seq_shift_add_multiplier.sv
// Directed and randomized bench for seq_shift_add_multiplier; expected
// products come from plain integer multiplication.
module tb_seq_shift_add_multiplier;

    localparam int unsigned N = 4;

    logic           clk;
    logic           rst_n;
    logic           start;
    logic [N-1:0]   multiplicand;
    logic [N-1:0]   multiplier;
    logic           busy;
    logic           done;
    logic [2*N-1:0] product;

    int checks = 0;
    int errors = 0;

    seq_shift_add_multiplier #(.N(N)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .busy         (busy),
        .done         (done),
        .product      (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [2*N-1:0] ref_mul(input logic [N-1:0] m, input logic [N-1:0] q);
        int unsigned p;
        p = int'(m) * int'(q);
        return p[2*N-1:0];
    endfunction

    // Launch one multiply from the current (IDLE) cycle; returns one cycle
    // after the done pulse, i.e. in the following IDLE cycle.
    task automatic run_mul(input string tag, input logic [N-1:0] m, input logic [N-1:0] q,
                           input bit disturb);
        int n;
        int busy_cycles;
        logic [2*N-1:0] exp;
        exp = ref_mul(m, q);
        multiplicand = m;
        multiplier   = q;
        start        = 1'b1;
        step();
        start        = 1'b0;
        n            = 0;
        busy_cycles  = 0;
        while (done !== 1'b1 && n < 3 * N) begin
            if (busy === 1'b1) busy_cycles++;
            if (disturb && n == 1) begin
                start        = 1'b1;
                multiplicand = ~m;
                multiplier   = ~q;
            end else begin
                start = 1'b0;
            end
            step();
            n++;
        end
        start = 1'b0;
        chk({tag, "_latency"}, n, N);
        chk({tag, "_busy_run"}, busy_cycles, N);
        chk({tag, "_busy_done"}, {31'd0, busy}, 1);
        chk({tag, "_product"}, {24'd0, product}, {24'd0, exp});
        step();
        chk({tag, "_done_pulse"}, {31'd0, done}, 0);
        chk({tag, "_idle"}, {31'd0, busy}, 0);
        chk({tag, "_hold"}, {24'd0, product}, {24'd0, exp});
        if (disturb) begin
            for (int i = 0; i < int'(N) + 2; i++) begin
                step();
                chk({tag, "_no_extra_done"}, {30'd0, busy, done}, 0);
            end
            chk({tag, "_hold_late"}, {24'd0, product}, {24'd0, exp});
        end
    endtask

    initial begin
        rst_n        = 1'b0;
        start        = 1'b1;
        multiplicand = 4'hF;
        multiplier   = 4'hF;
        step();
        step();
        chk("reset_busy", {31'd0, busy}, 0);
        chk("reset_done", {31'd0, done}, 0);
        chk("reset_product", {24'd0, product}, 0);
        start = 1'b0;
        rst_n = 1'b1;
        step();
        chk("idle_hold", {24'd0, product}, 0);

        run_mul("t1", 4'b1010, 4'b0110, 1'b0);
        chk("t1_const", {24'd0, product}, 32'h3C);
        run_mul("t2", 4'b1111, 4'b1111, 1'b0);
        chk("t2_const", {24'd0, product}, 32'hE1);
        run_mul("t3a", 4'b0000, 4'b1101, 1'b0);
        run_mul("t3b", 4'b1101, 4'b0000, 1'b0);
        chk("t3_const", {24'd0, product}, 0);
        run_mul("t4", 4'b1101, 4'b0101, 1'b1);
        chk("t4_const", {24'd0, product}, 32'h41);

        // Reset lands on the second RUN edge.
        multiplicand = 4'b0111;
        multiplier   = 4'b1100;
        start        = 1'b1;
        step();
        start = 1'b0;
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("t5_busy", {31'd0, busy}, 0);
        chk("t5_done", {31'd0, done}, 0);
        chk("t5_product", {24'd0, product}, 0);
        for (int i = 0; i < int'(N) + 3; i++) begin
            step();
            chk("t5_no_done", {30'd0, busy, done}, 0);
        end

        run_mul("t6a", 4'b1000, 4'b0100, 1'b0);
        chk("t6_hold_idle", {24'd0, product}, 32'h20);
        run_mul("t6b", 4'b0110, 4'b1100, 1'b0);
        chk("t6_const", {24'd0, product}, 32'h48);

        for (int i = 0; i < 24; i++) begin
            logic [N-1:0] rm;
            logic [N-1:0] rq;
            rm = N'($urandom);
            rq = N'($urandom);
            run_mul("rnd", rm, rq, ($urandom_range(0, 3) == 0));
            if ($urandom_range(0, 1) == 1) step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
